// File: rtl/delta_packer_pkg.sv
// Shared widths, code-kind and FSM state types for the delta packer.
// The short-code payload width here is only a default; delta_packer overrides it per instance.
package delta_packer_pkg;

    localparam int DATA_WIDTH          = 16;
    localparam int DEFAULT_SHORT_WIDTH = 4;

    typedef enum logic {
        CODE_SHORT = 1'b0,
        CODE_LONG  = 1'b1
    } code_kind_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFIX  = 2'd1,
        PAYLOAD = 2'd2
    } state_e;

endpackage

// File: rtl/delta_packer_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// Once the count reaches all-ones it holds there instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/delta_packer.sv
// Serialises signed deltas into a 1-bit prefix code: 0+short payload when the delta
// fits SHORT_WIDTH signed bits, else 1+full word. Counts completed codes of each kind.
module delta_packer
    import delta_packer_pkg::*;
#(
    parameter int SHORT_WIDTH = DEFAULT_SHORT_WIDTH,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_delta,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_bit,
    output logic                  out_valid,
    output logic                  out_first,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  short_cnt,
    output logic [CNT_WIDTH-1:0]  long_cnt
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    state_e                state, state_n;
    code_kind_e            kind, kind_n;
    logic [DATA_WIDTH-1:0] shift_reg, shift_n;
    logic [BIT_CNT_W-1:0]  bits_left, bits_left_n;
    logic                  out_bit_n, out_valid_n, out_first_n, out_last_n;

    logic [DATA_WIDTH-SHORT_WIDTH:0] top_bits;
    logic                            fits_short;
    logic                            last_xfer;
    logic                            accept;
    logic                            do_load, do_show, do_idle;

    // The delta fits the short code when everything from the short sign bit up is a copy of it.
    assign top_bits   = in_delta[DATA_WIDTH-1:SHORT_WIDTH-1];
    assign fits_short = (&top_bits) | ~(|top_bits);

    assign last_xfer = (state == PAYLOAD) && out_last && out_ready;
    assign in_ready  = reset_n && ((state == IDLE) || last_xfer);
    assign accept    = in_valid && in_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_n     = state;
        kind_n      = kind;
        shift_n     = shift_reg;
        bits_left_n = bits_left;
        out_bit_n   = out_bit;
        out_valid_n = out_valid;
        out_first_n = out_first;
        out_last_n  = out_last;
        do_load     = 1'b0;
        do_show     = 1'b0;
        do_idle     = 1'b0;

        case (state)
            IDLE:    do_load = accept;
            PREFIX:  do_show = out_ready;
            PAYLOAD: begin
                if (out_ready) begin
                    if (out_last) begin
                        do_load = accept;
                        do_idle = !accept;
                    end else begin
                        do_show = 1'b1;
                    end
                end
            end
            default: do_idle = 1'b1;
        endcase

        if (do_load) begin
            state_n     = PREFIX;
            kind_n      = fits_short ? CODE_SHORT : CODE_LONG;
            shift_n     = fits_short ? {in_delta[SHORT_WIDTH-1:0], {(DATA_WIDTH-SHORT_WIDTH){1'b0}}}
                                     : in_delta;
            bits_left_n = fits_short ? BIT_CNT_W'(SHORT_WIDTH) : BIT_CNT_W'(DATA_WIDTH);
            out_bit_n   = !fits_short;
            out_valid_n = 1'b1;
            out_first_n = 1'b1;
            out_last_n  = 1'b0;
        end

        // Present the next payload bit; it is the last one when only one was left to show.
        if (do_show) begin
            state_n     = PAYLOAD;
            out_bit_n   = shift_reg[DATA_WIDTH-1];
            shift_n     = shift_reg << 1;
            bits_left_n = bits_left - BIT_CNT_W'(1);
            out_first_n = 1'b0;
            out_last_n  = (bits_left == BIT_CNT_W'(1));
        end

        if (do_idle) begin
            state_n     = IDLE;
            out_bit_n   = 1'b0;
            out_valid_n = 1'b0;
            out_first_n = 1'b0;
            out_last_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            kind      <= CODE_SHORT;
            shift_reg <= '0;
            bits_left <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state     <= state_n;
            kind      <= kind_n;
            shift_reg <= shift_n;
            bits_left <= bits_left_n;
            out_bit   <= out_bit_n;
            out_valid <= out_valid_n;
            out_first <= out_first_n;
            out_last  <= out_last_n;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_short_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (last_xfer && (kind == CODE_SHORT)),
        .count   (short_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_long_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (last_xfer && (kind == CODE_LONG)),
        .count   (long_cnt)
    );

endmodule

// File: tb/tb_delta_packer.sv
// Directed bench for delta_packer: code formats, back-to-back, backpressure, reset, saturation.
// A second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_delta_packer;
    import delta_packer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in_delta;
    logic        in_valid;
    logic        in_ready;
    logic        out_bit, out_valid, out_first, out_last;
    logic        out_ready;
    logic [15:0] short_cnt, long_cnt;

    logic        s_in_ready, s_out_bit, s_out_valid, s_out_first, s_out_last;
    logic [1:0]  s_short_cnt, s_long_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    delta_packer #(.SHORT_WIDTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_delta(in_delta), .in_valid(in_valid),
        .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid),
        .out_first(out_first), .out_last(out_last), .out_ready(out_ready),
        .short_cnt(short_cnt), .long_cnt(long_cnt)
    );

    delta_packer #(.SHORT_WIDTH(4), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .in_delta(in_delta), .in_valid(in_valid),
        .in_ready(s_in_ready), .out_bit(s_out_bit), .out_valid(s_out_valid),
        .out_first(s_out_first), .out_last(s_out_last), .out_ready(out_ready),
        .short_cnt(s_short_cnt), .long_cnt(s_long_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted; afterwards the prefix bit is on the outputs.
    task automatic send(input logic [15:0] d);
        int guard = 0;
        in_delta = d;
        in_valid = 1'b1;
        while (!in_ready && guard < 40) begin
            step();
            guard++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Record one code (with out_ready held high) up to and including its out_last bit.
    task automatic collect(output logic [31:0] bits, output logic [31:0] firsts,
                           output logic [31:0] lasts, output int n);
        int  guard = 0;
        logic done = 1'b0;
        bits = '0; firsts = '0; lasts = '0; n = 0;
        while (!out_valid && guard < 40) begin
            step();
            guard++;
        end
        if (!out_valid) check("collect_timeout", 32'd0, 32'd1);
        while (out_valid && !done && n < 32) begin
            bits   = {bits[30:0], out_bit};
            firsts = {firsts[30:0], out_first};
            lasts  = {lasts[30:0], out_last};
            done   = out_last;
            n++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] b, f, l, v, r;
        logic [3:0]  b4;
        logic        sb, sl;
        int          n;

        reset_n = 1'b0; in_delta = '0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bits", 32'({out_bit, out_first, out_last}), 32'd0);
        check("rst_counts", 32'({short_cnt, long_cnt}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        step();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // 3 -> short: 0,0011
        send(16'd3);
        collect(b, f, l, n);
        check("d3_len", 32'(n), 32'd5);
        check("d3_bits", b, 32'b00011);
        check("d3_first", f, 32'b10000);
        check("d3_last", l, 32'b00001);
        check("d3_short_cnt", 32'(short_cnt), 32'd1);
        check("d3_idle", 32'(out_valid), 32'd0);

        // -8 -> short boundary: 0,1000
        send(16'hFFF8);
        collect(b, f, l, n);
        check("dm8_len", 32'(n), 32'd5);
        check("dm8_bits", b, 32'b01000);

        // 7 -> short upper boundary: 0,0111
        send(16'd7);
        collect(b, f, l, n);
        check("d7_bits", b, 32'b00111);
        check("d7_counts", 32'({short_cnt, long_cnt}), {16'd3, 16'd0});

        // 8 -> long: 1,0x0008
        send(16'd8);
        collect(b, f, l, n);
        check("d8_len", 32'(n), 32'd17);
        check("d8_bits", b, 32'h10008);
        check("d8_first", f, 32'h10000);
        check("d8_last", l, 32'h00001);
        check("d8_long_cnt", 32'(long_cnt), 32'd1);

        // most negative -> long: 1,0x8000
        send(16'h8000);
        collect(b, f, l, n);
        check("dmin_len", 32'(n), 32'd17);
        check("dmin_bits", b, 32'h18000);
        check("dmin_long_cnt", 32'(long_cnt), 32'd2);

        // Back-to-back 1 then -1 with in_valid held: 0,0001,0,1111 with no bubble
        in_delta = 16'd1; in_valid = 1'b1;
        step();
        in_delta = 16'hFFFF;
        v = '0; b = '0; r = '0;
        for (int i = 0; i < 10; i++) begin
            v = {v[30:0], out_valid};
            b = {b[30:0], out_bit};
            r = {r[30:0], in_ready};
            step();
            if (i == 4) in_valid = 1'b0;
        end
        check("b2b_valid", v, 32'h3FF);
        check("b2b_bits", b, 32'b0000101111);
        check("b2b_in_ready", r, 32'b0000100001);
        check("b2b_idle", 32'(out_valid), 32'd0);
        check("b2b_short_cnt", 32'(short_cnt), 32'd5);

        // Backpressure on 0x1234 (long): stall 5 cycles at the fifth bit
        send(16'h1234);
        b4 = '0;
        for (int i = 0; i < 4; i++) begin
            b4 = {b4[2:0], out_bit};
            step();
        end
        check("bp_head", 32'(b4), 32'b1000);
        sb = out_bit; sl = out_last;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold_bit", 32'(out_bit), 32'(sb));
            check("bp_hold_last", 32'(out_last), 32'(sl));
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_state", 32'(dut.state), 32'(PAYLOAD));
        end
        out_ready = 1'b1;
        collect(b, f, l, n);
        check("bp_tail_len", 32'(n), 32'd13);
        check("bp_tail_bits", b, 32'h1234);
        check("bp_long_cnt", 32'(long_cnt), 32'd3);

        // Reset in the middle of a long code
        send(16'h0100);
        step(); step();
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        step();
        check("midrst_outs", 32'({out_valid, out_bit, out_first, out_last}), 32'd0);
        check("midrst_counts", 32'({short_cnt, long_cnt}), 32'd0);
        reset_n = 1'b1;
        step();
        check("midrst_no_resume", 32'(out_valid), 32'd0);

        // Fresh code after reset: -2 -> 0,1110
        send(16'hFFFE);
        collect(b, f, l, n);
        check("post_rst_bits", b, 32'b01110);
        check("post_rst_counts", 32'({short_cnt, long_cnt}), {16'd1, 16'd0});

        // Saturation: 2-bit counters stop at 3 while the 16-bit ones keep counting
        for (int i = 0; i < 2; i++) begin
            send(16'd2);
            collect(b, f, l, n);
        end
        check("sat_at3_wide", 32'(short_cnt), 32'd3);
        check("sat_at3_narrow", 32'(s_short_cnt), 32'd3);
        for (int i = 0; i < 2; i++) begin
            send(16'hFFFD);
            collect(b, f, l, n);
        end
        check("sat_wide_5", 32'(short_cnt), 32'd5);
        check("sat_narrow_hold", 32'(s_short_cnt), 32'd3);
        check("sat_narrow_long", 32'(s_long_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
